sv_literal_tx: RTL and testbench

- Converts a numeric parameter value into the ASCII text of a sized or unsized SystemVerilog literal, for example 16'hDEAD, 4'b1010, 8'o377 or 'h2A.
- This is the transmit direction of the literal grammar that our parameter-default parser consumes.
- Feeds a byte-stream sink (UART or trace FIFO) so that elaborated parameter values can be dumped back as parseable source text.
- One request in, one character per accepted beat out, valid/ready on both sides.

---
 rtl/sv_literal_pkg.sv | 41 ++++
 rtl/sv_digit_char.sv | 18 +
 rtl/sv_literal_tx.sv | 158 +++++++++++++++
 tb/tb_sv_literal_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sv_literal_pkg.sv
// rtl/sv_literal_pkg.sv - shared types, ASCII constants and digit helpers for sv_literal_tx
package sv_literal_pkg;

  typedef enum logic [1:0] {
    BIN  = 2'd0,
    OCT  = 2'd1,
    HEX  = 2'd2,
    RSVD = 2'd3
  } base_e;

  typedef enum logic [2:0] {
    IDLE,
    W_TENS,
    W_ONES,
    TICK,
    BASE,
    DIGITS
  } state_e;

  localparam logic [7:0] CH_TICK = 8'h27;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_A_LO = 8'h61;
  localparam logic [7:0] CH_B    = 8'h62;
  localparam logic [7:0] CH_O    = 8'h6f;
  localparam logic [7:0] CH_H    = 8'h68;

  function automatic logic [2:0] bits_per_digit(base_e b);
    case (b)
      BIN:     return 3'd1;
      OCT:     return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  // ceil(w / b); w is at most 99 so w + b - 1 still fits in 7 bits
  function automatic logic [6:0] digit_count(logic [6:0] w, logic [2:0] b);
    return 7'((w + 7'(b) - 7'd1) / 7'(b));
  endfunction

endpackage

// File: rtl/sv_digit_char.sv
// rtl/sv_digit_char.sv - maps a 4-bit digit value to its ASCII character
module sv_digit_char
  import sv_literal_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       upper_hex,
  output logic [7:0] ch
);

  always_comb begin
    if (nibble < 4'd10) begin
      ch = CH_0 + {4'd0, nibble};
    end else begin
      ch = (upper_hex ? CH_A_UP : CH_A_LO) + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/sv_literal_tx.sv
// rtl/sv_literal_tx.sv - streams a numeric value as ASCII SystemVerilog literal text
module sv_literal_tx
  import sv_literal_pkg::*;
#(
  parameter int MAX_WIDTH = 32,
  parameter bit UPPER_HEX = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [MAX_WIDTH-1:0] req_value,
  input  logic [6:0]           req_width,
  input  logic [1:0]           req_base,
  input  logic                 req_sized,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_last
);

  localparam int         CNT_W  = $clog2(MAX_WIDTH + 1);
  localparam logic [6:0] MAX_W7 = 7'(MAX_WIDTH);

  state_e               state_q, state_d;
  logic [MAX_WIDTH-1:0] val_q, val_d;
  base_e                base_q, base_d;
  logic [6:0]           w_q, w_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [7:0]           out_data_q, out_data_d;

  logic                 hs;
  logic [6:0]           w_eff;
  logic [MAX_WIDTH-1:0] mask;
  logic [2:0]           bpd;
  logic [7:0]           sh_amt;
  logic [MAX_WIDTH+2:0] shifted;
  logic [3:0]           nib;
  logic [7:0]           nib_ch;

  assign req_ready = (state_q == IDLE);
  assign hs        = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  always_comb begin
    w_eff = ((req_width == 7'd0) || (req_width > MAX_W7)) ? MAX_W7 : req_width;
    mask  = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      mask[i] = (i < int'(w_eff));
    end
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    base_d  = base_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          val_d  = req_value & mask;
          base_d = (req_base == 2'd3) ? HEX : base_e'(req_base);
          w_d    = w_eff;
          if (!req_sized) begin
            state_d = TICK;
          end else if (w_eff >= 7'd10) begin
            state_d = W_TENS;
          end else begin
            state_d = W_ONES;
          end
        end
      end
      W_TENS: if (hs) state_d = W_ONES;
      W_ONES: if (hs) state_d = TICK;
      TICK:   if (hs) state_d = BASE;
      BASE: begin
        if (hs) begin
          state_d = DIGITS;
          cnt_d   = CNT_W'(digit_count(w_q, bits_per_digit(base_q)) - 7'd1);
        end
      end
      DIGITS: begin
        if (hs) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The character register is loaded with the text of the state being entered,
  // so the first character is already valid the cycle after accept.
  always_comb begin
    bpd     = bits_per_digit(base_d);
    sh_amt  = 8'(cnt_d) * 8'(bpd);
    shifted = {3'b000, val_d} >> sh_amt;
    case (state_d)
      W_TENS:  nib = 4'(w_d / 7'd10);
      W_ONES:  nib = 4'(w_d % 7'd10);
      default: nib = shifted[3:0] & ((bpd == 3'd1) ? 4'h1 : (bpd == 3'd3) ? 4'h7 : 4'hF);
    endcase
  end

  sv_digit_char u_digit_char (
    .nibble    (nib),
    .upper_hex (UPPER_HEX),
    .ch        (nib_ch)
  );

  always_comb begin
    out_valid_d = (state_d != IDLE);
    out_last_d  = (state_d == DIGITS) && (cnt_d == '0);
    case (state_d)
      W_TENS, W_ONES, DIGITS: out_data_d = nib_ch;
      TICK:                   out_data_d = CH_TICK;
      BASE: begin
        case (base_d)
          BIN:     out_data_d = CH_B;
          OCT:     out_data_d = CH_O;
          default: out_data_d = CH_H;
        endcase
      end
      default:                out_data_d = out_data_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      val_q       <= '0;
      base_q      <= HEX;
      w_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      base_q      <= base_d;
      w_q         <= w_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_sv_literal_tx.sv
// tb/tb_sv_literal_tx.sv - scoreboard bench for sv_literal_tx (upper- and lower-case hex instances)
module tb_sv_literal_tx;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_value;
  logic [6:0]  req_width;
  logic [1:0]  req_base;
  logic        req_sized;
  logic [1:0]  out_valid;
  logic        out_ready;
  logic [7:0]  out_data [2];
  logic [1:0]  out_last;

  int          tests;
  int          fails;
  int          beats [2];
  bit          bp;
  logic [8:0]  expq [2][$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sv_literal_tx #(
      .MAX_WIDTH (32),
      .UPPER_HEX (g == 0 ? 1'b1 : 1'b0)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_value (req_value),
      .req_width (req_width),
      .req_base  (req_base),
      .req_sized (req_sized),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_data  (out_data[g]),
      .out_last  (out_last[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitors: pop on every handshake; also require a stalled beat to hold still.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [8:0] held;
    bit         stalled;
    initial begin
      stalled = 1'b0;
      held    = '0;
      forever begin
        @(negedge clk);
        if (rst_n && out_valid[g]) begin
          if (stalled) chk($sformatf("stall_hold%0d", g), {23'd0, out_last[g], out_data[g]}, {23'd0, held});
          if (out_ready) begin
            if (expq[g].size() == 0) begin
              chk($sformatf("unexpected_beat%0d", g), {23'd0, out_last[g], out_data[g]}, 32'h0);
            end else begin
              chk($sformatf("beat%0d", g), {23'd0, out_last[g], out_data[g]}, {23'd0, expq[g].pop_front()});
            end
            beats[g]++;
            stalled = 1'b0;
          end else begin
            held    = {out_last[g], out_data[g]};
            stalled = 1'b1;
          end
        end else begin
          if (rst_n && stalled) chk($sformatf("valid_dropped%0d", g), 32'd0, 32'd1);
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int sel, input logic [31:0] v, input logic [6:0] w,
                       input logic [1:0] b, input logic s, input string exp);
    int k;
    k = 0;
    while (!req_ready[sel] && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("req_ready_wait", {31'd0, req_ready[sel]}, 32'd1);
    for (int i = 0; i < exp.len(); i++) begin
      expq[sel].push_back({(i == exp.len() - 1), exp[i]});
    end
    req_value      = v;
    req_width      = w;
    req_base       = b;
    req_sized      = s;
    req_valid[sel] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[sel] = 1'b0;
    chk("first_beat_latency", {31'd0, out_valid[sel]}, 32'd1);
  endtask

  task automatic send(input int sel, input logic [31:0] v, input logic [6:0] w,
                      input logic [1:0] b, input logic s, input string exp);
    int k;
    issue(sel, v, w, b, s, exp);
    k = 0;
    while (expq[sel].size() > 0 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({"done_", exp}, expq[sel].size(), 32'd0);
    expq[sel].delete();
    if (!bp) chk({"cycles_", exp}, k, exp.len());
  endtask

  initial begin
    int b0;
    int k;
    tests     = 0;
    fails     = 0;
    beats[0]  = 0;
    beats[1]  = 0;
    bp        = 1'b0;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_value = '0;
    req_width = '0;
    req_base  = '0;
    req_sized = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", {30'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data[0]}, 32'd0);
    chk("rst_out_last", {30'd0, out_last}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd3);

    send(0, 32'h0000DEAD, 7'd16, 2'd2, 1'b1, "16'hDEAD");
    send(0, 32'h0000000A, 7'd4,  2'd0, 1'b1, "4'b1010");
    send(0, 32'h000000FF, 7'd8,  2'd1, 1'b1, "8'o377");
    send(0, 32'h000001FF, 7'd9,  2'd1, 1'b1, "9'o777");
    send(0, 32'h0000002A, 7'd8,  2'd2, 1'b0, "'h2A");
    send(1, 32'h0000BEEF, 7'd16, 2'd2, 1'b1, "16'hbeef");
    send(0, 32'h000000FF, 7'd4,  2'd2, 1'b1, "4'hF");
    send(0, 32'hFFFFFFFF, 7'd32, 2'd1, 1'b1, "32'o37777777777");
    send(0, 32'h00000000, 7'd0,  2'd2, 1'b1, "32'h00000000");
    send(0, 32'h00001234, 7'd16, 2'd3, 1'b1, "16'h1234");
    send(0, 32'h00000005, 7'd100, 2'd0, 1'b0, "'b00000000000000000000000000000101");

    bp = 1'b1;
    send(0, 32'h0000DEAD, 7'd16, 2'd2, 1'b1, "16'hDEAD");
    send(0, 32'hCAFEF00D, 7'd32, 2'd2, 1'b1, "32'hCAFEF00D");
    send(1, 32'h0000BEEF, 7'd16, 2'd2, 1'b1, "16'hbeef");
    send(0, 32'h000000FF, 7'd8,  2'd1, 1'b1, "8'o377");
    bp = 1'b0;
    @(posedge clk);
    #1;

    b0 = beats[0];
    issue(0, 32'hCAFEF00D, 7'd32, 2'd2, 1'b1, "32'hCAFEF00D");
    k = 0;
    while (beats[0] < b0 + 3 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("midstream_beats", beats[0] - b0, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midstream_valid_drop", {31'd0, out_valid[0]}, 32'd0);
    expq[0].delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midstream_req_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("midstream_no_last", {31'd0, out_last[0]}, 32'd0);
    send(0, 32'h00000001, 7'd1, 2'd0, 1'b1, "1'b1");

    repeat (3) @(posedge clk);
    #1;
    chk("trailing_beats_q0", expq[0].size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
